// File: rtl/thor2023_mem_req_ring_if.sv
// Request/drain/forwarding bundle for the Thor2023 memory-request ring.
// master = issue/AGEN + cache side, slave = the ring itself.
interface thor2023_mem_req_ring_if #(
  parameter int AWID     = 32,
  parameter int DWID     = 128,
  parameter int QDEP     = 16,
  parameter int NPORTS   = 2,
  parameter int NTHREADS = 4
);
  localparam int NB = DWID / 8;
  localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int CW = $clog2(QDEP) + 1;

  // enqueue side
  logic [NPORTS-1:0]      wr;
  logic [NPORTS-1:0]      wr_ack;
  logic [NPORTS*AWID-1:0] i_adr;
  logic [NPORTS*DWID-1:0] i_dat;
  logic [NPORTS*NB-1:0]   i_sel;
  logic [NPORTS*2-1:0]    i_func;
  logic [NPORTS-1:0]      i_nc;
  logic [NPORTS*TW-1:0]   i_thread;
  logic [NPORTS*8-1:0]    i_tid;

  // drain side
  logic                   o_valid;
  logic                   o_ready;
  logic [AWID-1:0]        o_adr;
  logic [DWID-1:0]        o_dat;
  logic [NB-1:0]          o_sel;
  logic [1:0]             o_func;
  logic                   o_nc;
  logic [TW-1:0]          o_thread;
  logic [7:0]             o_tid;

  // forwarding, squash and status
  logic [NPORTS-1:0]      found;
  logic [NPORTS*DWID-1:0] ld_dat;
  logic [NTHREADS-1:0]    rollback;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;

  modport master (
    output wr, i_adr, i_dat, i_sel, i_func, i_nc, i_thread, i_tid, o_ready, rollback,
    input  wr_ack, o_valid, o_adr, o_dat, o_sel, o_func, o_nc, o_thread, o_tid,
           found, ld_dat, count, full, empty
  );

  modport slave (
    input  wr, i_adr, i_dat, i_sel, i_func, i_nc, i_thread, i_tid, o_ready, rollback,
    output wr_ack, o_valid, o_adr, o_dat, o_sel, o_func, o_nc, o_thread, o_tid,
           found, ld_dat, count, full, empty
  );
endinterface

// File: rtl/thor2023_mem_req_ring.sv
// Multi-port circular memory-request queue: in-order multi-accept enqueue,
// duplicate-tid suppression, youngest-store load forwarding, per-thread
// rollback leaving holes that the drain side skips one per cycle.
module thor2023_mem_req_ring #(
  parameter int AWID        = 32,
  parameter int DWID        = 128,
  parameter int QDEP        = 16,
  parameter int NPORTS      = 2,
  parameter int NTHREADS    = 4,
  parameter int LOAD_BYPASS = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  thor2023_mem_req_ring_if.slave bus
);
  localparam int NB   = DWID / 8;
  localparam int TW   = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int PW   = $clog2(QDEP);
  localparam int CW   = PW + 1;
  localparam int BOFF = $clog2(NB);

  localparam logic [1:0] F_LOAD  = 2'd0;
  localparam logic [1:0] F_LOADZ = 2'd1;
  localparam logic [1:0] F_STORE = 2'd2;
  localparam logic [1:0] F_RSVD  = 2'd3;

  // ring payload and per-slot valid bits
  logic [AWID-1:0] s_adr  [QDEP];
  logic [DWID-1:0] s_dat  [QDEP];
  logic [NB-1:0]   s_sel  [QDEP];
  logic [1:0]      s_func [QDEP];
  logic [TW-1:0]   s_thr  [QDEP];
  logic [7:0]      s_tid  [QDEP];
  logic [QDEP-1:0] s_nc;
  logic [QDEP-1:0] s_valid, valid_nxt;

  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count, free_slots, n_enq;
  logic [NPORTS-1:0] ack_nxt, we, wr_ack_q, found;
  logic [PW-1:0]     wslot [NPORTS];
  logic              head_live, pop, skip, adv, dup;
  logic [PW-1:0]     fidx;

  // per-port views of the flat request buses
  logic [AWID-1:0] p_adr  [NPORTS];
  logic [DWID-1:0] p_dat  [NPORTS];
  logic [NB-1:0]   p_sel  [NPORTS];
  logic [1:0]      p_func [NPORTS];
  logic [TW-1:0]   p_thr  [NPORTS];
  logic [7:0]      p_tid  [NPORTS];
  logic [DWID-1:0] fwd_dat [NPORTS];

  // Slice the flat port buses into per-port fields.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      p_adr[p]  = bus.i_adr[p*AWID +: AWID];
      p_dat[p]  = bus.i_dat[p*DWID +: DWID];
      p_sel[p]  = bus.i_sel[p*NB +: NB];
      p_func[p] = bus.i_func[p*2 +: 2];
      p_thr[p]  = bus.i_thread[p*TW +: TW];
      p_tid[p]  = bus.i_tid[p*8 +: 8];
    end
  end

  // Holes (occupied but invalid) at head are retired without presenting.
  assign head_live  = (count != '0) && s_valid[head];
  assign pop        = head_live && bus.o_ready;
  assign skip       = (count != '0) && !s_valid[head];
  assign adv        = pop | skip;
  assign free_slots = CW'(QDEP) - count;

  // Youngest-store lookup: scan head->tail so the last hit is nearest tail.
  always_comb begin
    found = '0;
    fidx  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      fwd_dat[p] = '0;
      if (LOAD_BYPASS != 0 && !bus.i_nc[p] && (p_func[p] == F_LOAD || p_func[p] == F_LOADZ)) begin
        for (int k = 0; k < QDEP; k++) begin
          fidx = head + PW'(k);
          if (s_valid[fidx] && s_func[fidx] == F_STORE &&
              s_adr[fidx][AWID-1:BOFF] == p_adr[p][AWID-1:BOFF] &&
              ((s_sel[fidx] & p_sel[p]) == p_sel[p])) begin
            found[p]   = 1'b1;
            fwd_dat[p] = s_dat[fidx];
          end
        end
      end
    end
  end

  // Forwarded data keeps only the bytes the load asked for.
  always_comb begin
    bus.ld_dat = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int b = 0; b < NB; b++)
        bus.ld_dat[p*DWID + b*8 +: 8] = p_sel[p][b] ? fwd_dat[p][b*8 +: 8] : 8'h00;
  end

  // Port arbitration in index order against the free count seen at cycle start.
  // NOTE: every variable in a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    ack_nxt = '0;
    we      = '0;
    n_enq   = '0;
    dup     = 1'b0;
    for (int p = 0; p < NPORTS; p++) wslot[p] = '0;
    for (int p = 0; p < NPORTS; p++) begin
      dup = 1'b0;
      if (bus.wr[p] && p_func[p] != F_RSVD && !bus.rollback[p_thr[p]]) begin
        for (int s = 0; s < QDEP; s++)
          if (s_valid[s] && s_tid[s] == p_tid[p]) dup = 1'b1;
        for (int q = 0; q < p; q++)
          if (we[q] && p_tid[q] == p_tid[p]) dup = 1'b1;
        if (dup || found[p]) begin
          ack_nxt[p] = 1'b1;
        end else if (n_enq < free_slots) begin
          we[p]      = 1'b1;
          wslot[p]   = tail + n_enq[PW-1:0];
          n_enq      = n_enq + CW'(1);
          ack_nxt[p] = 1'b1;
        end
      end
    end
  end

  // Valid bits: rollback clears, head retirement clears, new writes set.
  always_comb begin
    valid_nxt = s_valid;
    for (int s = 0; s < QDEP; s++)
      if (s_valid[s] && bus.rollback[s_thr[s]]) valid_nxt[s] = 1'b0;
    if (adv) valid_nxt[head] = 1'b0;
    for (int p = 0; p < NPORTS; p++)
      if (we[p]) valid_nxt[wslot[p]] = 1'b1;
  end

  // Pointer, occupancy and acknowledge state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      s_valid  <= '0;
      wr_ack_q <= '0;
    end else begin
      head     <= head + PW'(adv);
      tail     <= tail + n_enq[PW-1:0];
      count    <= count + n_enq - CW'(adv);
      s_valid  <= valid_nxt;
      wr_ack_q <= ack_nxt;
    end
  end

  // Slot payload write.
  // NOTE: payload RAM is not reset; the valid bits alone decide occupancy.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (we[p]) begin
        s_adr[wslot[p]]  <= p_adr[p];
        s_dat[wslot[p]]  <= p_dat[p];
        s_sel[wslot[p]]  <= p_sel[p];
        s_func[wslot[p]] <= p_func[p];
        s_thr[wslot[p]]  <= p_thr[p];
        s_tid[wslot[p]]  <= p_tid[p];
        s_nc[wslot[p]]   <= bus.i_nc[p];
      end
    end
  end

  assign bus.found    = found;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.o_valid  = head_live;
  assign bus.o_adr    = s_adr[head];
  assign bus.o_dat    = s_dat[head];
  assign bus.o_sel    = s_sel[head];
  assign bus.o_func   = s_func[head];
  assign bus.o_nc     = s_nc[head];
  assign bus.o_thread = s_thr[head];
  assign bus.o_tid    = s_tid[head];
  assign bus.count    = count;
  assign bus.full     = (count == CW'(QDEP));
  assign bus.empty    = (count == '0);
endmodule

// File: tb/tb_thor2023_mem_req_ring.sv
// Bench for thor2023_mem_req_ring: directed scenarios followed by random
// traffic, all compared against an in-order queue model of the ring.
module tb_thor2023_mem_req_ring;
  localparam int AWID = 32;
  localparam int DWID = 128;
  localparam int QDEP = 16;
  localparam int NP   = 2;
  localparam int NT   = 4;
  localparam int NB   = 16;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] STORE = 2'd2;

  typedef struct {
    logic [31:0]  adr;
    logic [127:0] dat;
    logic [15:0]  sel;
    logic [1:0]   func;
    logic         nc;
    logic [1:0]   thr;
    logic [7:0]   tid;
    logic         vld;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   ntid = 32;
  ent_t q[$];

  thor2023_mem_req_ring_if #(.AWID(AWID), .DWID(DWID), .QDEP(QDEP), .NPORTS(NP), .NTHREADS(NT)) bus ();

  thor2023_mem_req_ring #(.AWID(AWID), .DWID(DWID), .QDEP(QDEP), .NPORTS(NP), .NTHREADS(NT),
                          .LOAD_BYPASS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] byte_mask(input logic [15:0] sel);
    logic [127:0] m = '0;
    for (int b = 0; b < NB; b++) if (sel[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic drive(input int p, input logic w, input logic [1:0] f, input logic [31:0] a,
                       input logic [127:0] d, input logic [15:0] s, input logic nc,
                       input logic [1:0] th, input logic [7:0] tid);
    bus.wr[p]                 = w;
    bus.i_func[p*2 +: 2]      = f;
    bus.i_adr[p*AWID +: AWID] = a;
    bus.i_dat[p*DWID +: DWID] = d;
    bus.i_sel[p*NB +: NB]     = s;
    bus.i_nc[p]               = nc;
    bus.i_thread[p*2 +: 2]    = th;
    bus.i_tid[p*8 +: 8]       = tid;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, LOAD, 32'h0, 128'h0, 16'h0, 1'b0, 2'd0, 8'd0);
    bus.rollback = '0;
  endtask

  function automatic logic [7:0] new_tid();
    ntid = (ntid + 1) % 256;
    return 8'(ntid);
  endfunction

  // One clock of traffic: checks outputs against the model, advances both.
  task automatic cycle();
    int           cnt, free;
    logic         ov, pop, skip, f, dup, ordy;
    logic [3:0]   rb;
    logic [NP-1:0] exp_ack;
    logic [127:0] d;
    ent_t         nw[$];
    ent_t         e;
    #1;
    cnt = q.size();
    check("count", 128'(bus.count), 128'(cnt));
    check("empty", 128'(bus.empty), 128'(cnt == 0));
    check("full", 128'(bus.full), 128'(cnt == QDEP));
    ov = (cnt != 0) && q[0].vld;
    check("o_valid", 128'(bus.o_valid), 128'(ov));
    if (ov) begin
      check("o_adr", 128'(bus.o_adr), 128'(q[0].adr));
      check("o_dat", bus.o_dat, q[0].dat);
      check("o_tid", 128'(bus.o_tid), 128'(q[0].tid));
      check("o_thread", 128'(bus.o_thread), 128'(q[0].thr));
      check("o_func", 128'(bus.o_func), 128'(q[0].func));
    end
    ordy = bus.o_ready;
    rb   = bus.rollback;
    pop  = ov && ordy;
    skip = (cnt != 0) && !q[0].vld;
    free = QDEP - cnt;
    exp_ack = '0;
    for (int p = 0; p < NP; p++) begin
      logic [31:0]  a   = bus.i_adr[p*AWID +: AWID];
      logic [15:0]  s   = bus.i_sel[p*NB +: NB];
      logic [1:0]   fn  = bus.i_func[p*2 +: 2];
      logic         nc  = bus.i_nc[p];
      logic [1:0]   th  = bus.i_thread[p*2 +: 2];
      logic [7:0]   tid = bus.i_tid[p*8 +: 8];
      f = 1'b0;
      d = '0;
      if (!nc && fn < 2'd2)
        foreach (q[i])
          if (q[i].vld && q[i].func == STORE && q[i].adr[31:4] == a[31:4] && ((q[i].sel & s) == s)) begin
            f = 1'b1;
            d = q[i].dat & byte_mask(s);
          end
      check($sformatf("found%0d", p), 128'(bus.found[p]), 128'(f));
      check($sformatf("ld_dat%0d", p), bus.ld_dat[p*DWID +: DWID], d);
      if (bus.wr[p] && fn != 2'd3 && !rb[th]) begin
        dup = 1'b0;
        foreach (q[i]) if (q[i].vld && q[i].tid == tid) dup = 1'b1;
        foreach (nw[j]) if (nw[j].tid == tid) dup = 1'b1;
        if (dup || f) exp_ack[p] = 1'b1;
        else if (nw.size() < free) begin
          e = '{adr: a, dat: bus.i_dat[p*DWID +: DWID], sel: s, func: fn, nc: nc, thr: th, tid: tid, vld: 1'b1};
          nw.push_back(e);
          exp_ack[p] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop || skip) void'(q.pop_front());
    for (int i = 0; i < q.size(); i++)
      if (q[i].vld && rb[q[i].thr]) begin
        e = q[i];
        e.vld = 1'b0;
        q[i] = e;
      end
    foreach (nw[j]) q.push_back(nw[j]);
    check("wr_ack", 128'(bus.wr_ack), 128'(exp_ack));
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    bus.o_ready = 1'b1;
    for (int i = 0; i < 4 * QDEP && q.size() != 0; i++) cycle();
    check("drained_empty", 128'(bus.empty), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dat_a, dat_b;
    logic [3:0]   pat;
    logic [7:0]   t1, t_dup;
    logic [31:0]  adrs [4];
    logic [15:0]  sl;
    int           k;

    adrs  = '{32'h100, 32'h104, 32'h200, 32'h310};
    rst_n = 1'b0;
    bus.o_ready = 1'b0;
    idle();
    #1;
    check("rst_count", 128'(bus.count), 128'(0));
    check("rst_empty", 128'(bus.empty), 128'(1));
    check("rst_full", 128'(bus.full), 128'(0));
    check("rst_o_valid", 128'(bus.o_valid), 128'(0));
    check("rst_wr_ack", 128'(bus.wr_ack), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single store becomes visible at head
    drive(0, 1'b1, STORE, 32'h100, 128'h11, 16'hFFFF, 1'b0, 2'd0, 8'd1);
    cycle();
    idle();
    check("first_ack", 128'(bus.wr_ack), 128'(2'b01));
    check("first_count", 128'(bus.count), 128'(1));
    check("first_o_valid", 128'(bus.o_valid), 128'(1));
    check("first_o_adr", 128'(bus.o_adr), 128'(32'h100));

    // fill to full with the drain stalled
    for (int i = 0; i < 20 && q.size() < QDEP; i++) begin
      for (int p = 0; p < NP; p++)
        drive(p, 1'b1, STORE, 32'h400 + 32'(i * 16), 128'(i), 16'hFFFF, 1'b0, 2'(p), new_tid());
      cycle();
    end
    check("fill_full", 128'(bus.full), 128'(1));
    for (int p = 0; p < NP; p++) drive(p, 1'b1, STORE, 32'h500, 128'h5, 16'hFFFF, 1'b0, 2'd0, new_tid());
    cycle();
    check("full_reject_ack", 128'(bus.wr_ack), 128'(0));
    check("full_hold_count", 128'(bus.count), 128'(16));
    bus.o_ready = 1'b1;
    cycle();
    check("full_pop_ack", 128'(bus.wr_ack), 128'(0));
    check("full_pop_count", 128'(bus.count), 128'(15));

    // one free slot: only port 0 fits, port 1 retries
    t1 = new_tid();
    drive(0, 1'b1, STORE, 32'h600, 128'h6, 16'hFFFF, 1'b0, 2'd0, new_tid());
    drive(1, 1'b1, STORE, 32'h610, 128'h7, 16'hFFFF, 1'b0, 2'd1, t1);
    cycle();
    check("c15_ack", 128'(bus.wr_ack), 128'(2'b01));
    drive(0, 1'b0, LOAD, 32'h0, 128'h0, 16'h0, 1'b0, 2'd0, 8'd0);
    cycle();
    check("retry_ack", 128'(bus.wr_ack), 128'(2'b10));
    drain();

    // forwarding from the youngest store
    dat_a = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    dat_b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.o_ready = 1'b0;
    drive(0, 1'b1, STORE, 32'h200, dat_a, 16'h00FF, 1'b0, 2'd0, new_tid());
    cycle();
    drive(0, 1'b1, STORE, 32'h200, dat_b, 16'h00FF, 1'b0, 2'd0, new_tid());
    cycle();
    drive(0, 1'b1, LOAD, 32'h200, 128'h0, 16'h000F, 1'b0, 2'd2, new_tid());
    #1;
    check("fwd_found", 128'(bus.found[0]), 128'(1));
    check("fwd_ld_dat", bus.ld_dat[DWID-1:0], 128'h7654_3210);
    cycle();
    check("fwd_ack", 128'(bus.wr_ack), 128'(2'b01));
    check("fwd_no_enq", 128'(bus.count), 128'(2));
    drive(0, 1'b1, LOAD, 32'h200, 128'h0, 16'h000F, 1'b1, 2'd2, new_tid());
    #1;
    check("nc_found", 128'(bus.found[0]), 128'(0));
    cycle();
    check("nc_enq", 128'(bus.count), 128'(3));
    drain();

    // rollback of thread 0 leaves holes that drain skips
    bus.o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, STORE, 32'h700, 128'h70, 16'hFFFF, 1'b0, 2'd0, new_tid());
      drive(1, 1'b1, STORE, 32'h710, 128'h71, 16'hFFFF, 1'b0, 2'd1, new_tid());
      cycle();
    end
    idle();
    bus.rollback = 4'b0001;
    cycle();
    idle();
    bus.o_ready = 1'b1;
    pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      check("rb_o_valid", 128'(bus.o_valid), 128'(pat[i]));
      cycle();
    end
    check("rb_count", 128'(bus.count), 128'(0));

    // duplicate tid is acked without consuming a slot
    bus.o_ready = 1'b0;
    t_dup = new_tid();
    drive(0, 1'b1, STORE, 32'h800, 128'h80, 16'hFFFF, 1'b0, 2'd0, t_dup);
    cycle();
    cycle();
    check("dup_ack", 128'(bus.wr_ack), 128'(2'b01));
    check("dup_count", 128'(bus.count), 128'(1));

    // asynchronous reset mid-operation
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 128'(bus.count), 128'(0));
    check("mid_rst_o_valid", 128'(bus.o_valid), 128'(0));
    check("mid_rst_wr_ack", 128'(bus.wr_ack), 128'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) begin
        k  = int'($urandom_range(0, 3));
        sl = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h00FF : (k == 2) ? 16'h000F : 16'($urandom);
        drive(p, $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), adrs[$urandom_range(0, 3)],
              {$urandom, $urandom, $urandom, $urandom}, sl, $urandom_range(0, 7) == 0,
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 23)));
      end
      bus.o_ready  = 1'($urandom_range(0, 1));
      bus.rollback = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
